rv32im_bus_arbiter: RTL and testbench
=====================================

# rv32im_bus_arbiter

Round-robin arbiter that shares the single Wishbone master port of the RV32IM core between several bus requesters, e.g. instruction fetch (index 0) and the load/store unit (index 1). It answers each requester's `ctrl_req` with a one-hot `ctrl_grant`, muxes the owner's Wishbone signals onto the shared bus and routes `ack`/`err` back to the owner only. An optional watchdog terminates stalled transactions with a bus error.

## Interface
- `XLEN`, 32: data and address width.
- `NUM_MASTERS`, 2: number of requesters, at least 2.
- `TIMEOUT_CYCLES`, 255: watchdog limit in cycles. Used only with `BUS_ARBITER_TIMEOUT_EN`.

Ports:
- `clk_i` input 1: clock, rising edge.
- `clear_i` input 1: reset, asynchronous, active-high.
- `ctrl_req_i` input NUM_MASTERS: per-requester bus request.
- `ctrl_grant_o` output NUM_MASTERS: one-hot grant, registered.
- `m_adr_i` input NUM_MASTERS*(XLEN-2): word addresses; master i occupies slice i.
- `m_dat_i` input NUM_MASTERS*XLEN: write data.
- `m_sel_i` input NUM_MASTERS*4: byte selects.
- `m_stb_i`, `m_cyc_i`, `m_we_i` input NUM_MASTERS each: per-master strobe, cycle and write-enable.
- `m_dat_o` output XLEN: read data, broadcast to all masters (equals `s_dat_i`).
- `m_ack_o`, `m_err_o` output NUM_MASTERS each: per-master termination.
- `s_adr_o` output XLEN-2; `s_dat_o` output XLEN; `s_sel_o` output 4: shared bus address, data and byte selects.
- `s_stb_o`, `s_cyc_o`, `s_we_o` output 1 each: shared bus controls.
- `s_dat_i` input XLEN; `s_ack_i`, `s_err_i` input 1 each: slave responses.
- `timeout_o` output 1: one-cycle watchdog pulse.

## Operation
- States:
  - IDLE: no owner.
  - OWNED: owner index `own` is valid.
  - GAP: one dead cycle after a release.
- Priority pointer `last` holds the most recent owner. The search order is last+1, last+2, … modulo NUM_MASTERS.
- IDLE with any `ctrl_req_i` bit set:
  - Select the first requester in search order.
  - Set the `ctrl_grant_o` bit for that requester.
  - Set `own` and `last` to that requester.
  - Go to OWNED.
- OWNED with `ctrl_req_i[own]` high: hold. There is no preemption, regardless of other requests.
- OWNED with `ctrl_req_i[own]` low: clear `ctrl_grant_o` and go to GAP.
- GAP: unconditionally go to IDLE. No grant is ever issued in GAP.
- Shared bus mux, combinational:
  - In OWNED, `s_*_o` carry the owner's signals, with `s_stb_o = m_stb_i[own]` and `s_cyc_o = m_cyc_i[own]`.
  - Otherwise `s_stb_o`, `s_cyc_o`, `s_we_o`, `s_sel_o`, `s_adr_o` and `s_dat_o` are all 0.
- Response routing:
  - `m_ack_o[own] = s_ack_i & s_cyc_o`, and likewise for `m_err_o`.
  - All non-owner bits are 0.
  - Slave responses while `s_cyc_o` is 0 are dropped.
- A requester dropping `ctrl_req` while its strobe is still high is a protocol violation. The arbiter still releases, and `s_stb_o` falls the same cycle the grant clears.
- Reset values:
  - `ctrl_grant_o` = 0, state = IDLE, `last` = NUM_MASTERS-1, so master 0 wins first.
  - `timeout_o` = 0, watchdog counter = 0.
  - Asserting `clear_i` mid-transaction immediately drops the grant and therefore `s_stb_o`/`s_cyc_o`. Pending slave responses are dropped.

## Timing
- Request to grant: `ctrl_req_i[i]` sampled high at edge k in IDLE gives `ctrl_grant_o[i]` = 1 after edge k.
- Release: `ctrl_req_i[own]` sampled low at edge k clears the grant after edge k. GAP occupies k..k+1, and the earliest new grant follows edge k+2.
- Minimum hand-over is 2 cycles with all grants 0.
- Simultaneous requests from all masters are served in strict rotation.
- A request re-raised by the previous owner during GAP has the lowest priority at the next IDLE edge.
- Mux and ack/err routing add zero cycles. Master i's strobe at edge n appears as `s_stb_o` in the same cycle.

## Configuration
- Macro `BUS_ARBITER_TIMEOUT_EN`.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) increments each cycle that `s_stb_o & ~s_ack_i & ~s_err_i` holds.
  - It clears on any `s_ack_i`/`s_err_i`, when `s_stb_o` is low, and on leaving OWNED.
  - When the counter equals TIMEOUT_CYCLES, the arbiter pulses `m_err_o[own]` and `timeout_o` for exactly one cycle and clears the counter.
  - The owner then sees an ordinary bus error.
- Undefined:
  - No counter is built and `TIMEOUT_CYCLES` is ignored.
  - `timeout_o` is tied to 0.
  - `m_err_o` comes only from `s_err_i`.

## Test plan
- **Reset, single request:** after reset, raise `ctrl_req_i` = 2'b10 -> `ctrl_grant_o` = 2'b10 one edge later; `s_adr_o` follows `m_adr_i` slice 1.
- **Contention:** `ctrl_req_i` = 2'b11 from reset -> master 0 granted first. When master 0 drops its request, grant goes 2'b01 -> 2'b00 for 2 cycles -> 2'b10.
- **Ack routing:** owner 1 strobes address 0x100, slave returns `s_ack_i` with `s_dat_i` = 0xDEADBEEF -> `m_ack_o` = 2'b10, `m_dat_o` = 0xDEADBEEF, and `m_ack_o[0]` stays 0 throughout.
- **Error routing:** slave asserts `s_err_i` during owner 0's transfer -> `m_err_o` = 2'b01 for that cycle; a spurious `s_err_i` in IDLE yields `m_err_o` = 0.
- **Reset mid-transfer:** assert `clear_i` asynchronously mid-transfer -> `ctrl_grant_o`, `s_stb_o` and `s_cyc_o` read 0 before the next clock edge.
- **Watchdog:** with the macro defined and TIMEOUT_CYCLES = 8, hold strobe with no ack -> `m_err_o[own]` and `timeout_o` high for one cycle exactly 8 cycles after `s_stb_o` rose. Without the macro the bus stays stalled and `timeout_o` = 0.

Source files
------------

// File: rtl/rv32im_bus_arbiter.sv
// rtl/rv32im_bus_arbiter.sv - round-robin Wishbone arbiter for the RV32IM core master port
// Optional watchdog: define BUS_ARBITER_TIMEOUT_EN to terminate stalled strobes with a bus error.
module rv32im_bus_arbiter #(
  parameter int XLEN           = 32,
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk_i,
  input  logic                          clear_i,
  input  logic [NUM_MASTERS-1:0]        ctrl_req_i,
  output logic [NUM_MASTERS-1:0]        ctrl_grant_o,
  input  logic [NUM_MASTERS*(XLEN-2)-1:0] m_adr_i,
  input  logic [NUM_MASTERS*XLEN-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*4-1:0]      m_sel_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  output logic [XLEN-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [XLEN-3:0]               s_adr_o,
  output logic [XLEN-1:0]               s_dat_o,
  output logic [3:0]                    s_sel_o,
  output logic                          s_stb_o,
  output logic                          s_cyc_o,
  output logic                          s_we_o,
  input  logic [XLEN-1:0]               s_dat_i,
  input  logic                          s_ack_i,
  input  logic                          s_err_i,
  output logic                          timeout_o
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int AW = XLEN - 2;

  // Reject configurations the rotation and watchdog logic cannot serve.
  if (NUM_MASTERS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_config
    $error("rv32im_bus_arbiter: NUM_MASTERS must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, OWNED, GAP} state_t;

  state_t          state;
  logic [IW-1:0]   own;
  logic [IW-1:0]   last;
  logic [IW-1:0]   pick;
  logic            found;
  logic            owned;

  assign owned = (state == OWNED);

  // Round-robin search: first requester after the previous owner wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!found && ctrl_req_i[(int'(last) + k) % NUM_MASTERS]) begin
        found = 1'b1;
        pick  = IW'((int'(last) + k) % NUM_MASTERS);
      end
    end
  end

  // Ownership FSM with registered one-hot grant; GAP forces one dead cycle after release.
  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      state        <= IDLE;
      own          <= '0;
      last         <= IW'(NUM_MASTERS - 1);
      ctrl_grant_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state        <= OWNED;
            own          <= pick;
            last         <= pick;
            ctrl_grant_o <= NUM_MASTERS'(1) << pick;
          end
        end
        OWNED: begin
          if (!ctrl_req_i[own]) begin
            state        <= GAP;
            ctrl_grant_o <= '0;
          end
        end
        GAP: state <= IDLE;
        default: begin
          state        <= IDLE;
          ctrl_grant_o <= '0;
        end
      endcase
    end
  end

  // Zero-latency mux of the owner onto the shared bus and response routing back to it.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    s_we_o  = 1'b0;
    m_ack_o = '0;
    m_err_o = '0;
    m_dat_o = s_dat_i;
    if (owned) begin
      s_adr_o      = m_adr_i[int'(own)*AW +: AW];
      s_dat_o      = m_dat_i[int'(own)*XLEN +: XLEN];
      s_sel_o      = m_sel_i[int'(own)*4 +: 4];
      s_stb_o      = m_stb_i[own];
      s_cyc_o      = m_cyc_i[own];
      s_we_o       = m_we_i[own];
      m_ack_o[own] = s_ack_i & s_cyc_o;
      m_err_o[own] = (s_err_i & s_cyc_o) | timeout_o;
    end
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt;

  // The pulse is decoded from the counter so it lands exactly TIMEOUT_CYCLES after the strobe rose.
  assign timeout_o = owned && (wd_cnt == CW'(TIMEOUT_CYCLES));

  // Count stalled strobe cycles; any termination, idle strobe, pulse or release restarts it.
  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      wd_cnt <= '0;
    end else if (!owned || !ctrl_req_i[own] || !s_stb_o || s_ack_i || s_err_i || timeout_o) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_rv32im_bus_arbiter.sv
// tb/tb_rv32im_bus_arbiter.sv - self-checking bench for rv32im_bus_arbiter
module tb_rv32im_bus_arbiter;

  localparam int XLEN = 32;
  localparam int N    = 2;
  localparam int AW   = XLEN - 2;
  localparam int TO   = 8;

  logic              clk = 1'b0;
  logic              clear_i;
  logic [N-1:0]      req;
  logic [N-1:0]      grant;
  logic [AW-1:0]     adr [N];
  logic [XLEN-1:0]   wdat [N];
  logic [3:0]        sel [N];
  logic [N-1:0]      stb, cyc, we;
  logic [XLEN-1:0]   m_dat_o;
  logic [N-1:0]      m_ack_o, m_err_o;
  logic [AW-1:0]     s_adr_o;
  logic [XLEN-1:0]   s_dat_o;
  logic [3:0]        s_sel_o;
  logic              s_stb_o, s_cyc_o, s_we_o;
  logic [XLEN-1:0]   s_dat_i;
  logic              s_ack_i, s_err_i;
  logic              timeout_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rv32im_bus_arbiter #(.XLEN(XLEN), .NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .clear_i(clear_i), .ctrl_req_i(req), .ctrl_grant_o(grant),
    .m_adr_i({adr[1], adr[0]}), .m_dat_i({wdat[1], wdat[0]}), .m_sel_i({sel[1], sel[0]}),
    .m_stb_i(stb), .m_cyc_i(cyc), .m_we_i(we),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_we_o(s_we_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .timeout_o(timeout_o)
  );

  // Reference model: owner index (-1 = none), dead-cycle flag, rotation pointer, stall count.
  int m_owner, m_last, m_wd;
  bit m_gap;

  function automatic void model_reset();
    m_owner = -1; m_gap = 1'b0; m_last = N - 1; m_wd = 0;
  endfunction

  function automatic bit exp_timeout();
`ifdef BUS_ARBITER_TIMEOUT_EN
    return (m_owner >= 0) && (m_wd == TO);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_step();
    bit to;
    bit got;
    int c;
    to = exp_timeout();
    if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner = -1; m_gap = 1'b1; m_wd = 0;
      end else if (to) m_wd = 0;
      else if (stb[m_owner] && !s_ack_i && !s_err_i) m_wd = m_wd + 1;
      else m_wd = 0;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      got = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!got && req[c]) begin got = 1'b1; m_owner = c; m_last = c; end
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [N-1:0] eg, ea, ee;
    logic ecyc;
    eg = '0; ea = '0; ee = '0; ecyc = 1'b0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ecyc = cyc[m_owner];
      ea[m_owner] = s_ack_i & ecyc;
      ee[m_owner] = (s_err_i & ecyc) | exp_timeout();
    end
    chk("rnd_grant", grant, eg);
    chk("rnd_stb", s_stb_o, m_owner >= 0 ? stb[m_owner] : 1'b0);
    chk("rnd_cyc", s_cyc_o, ecyc);
    chk("rnd_we", s_we_o, m_owner >= 0 ? we[m_owner] : 1'b0);
    chk("rnd_adr", s_adr_o, m_owner >= 0 ? adr[m_owner] : '0);
    chk("rnd_dat", s_dat_o, m_owner >= 0 ? wdat[m_owner] : '0);
    chk("rnd_sel", s_sel_o, m_owner >= 0 ? sel[m_owner] : '0);
    chk("rnd_ack", m_ack_o, ea);
    chk("rnd_err", m_err_o, ee);
    chk("rnd_rdat", m_dat_o, s_dat_i);
    chk("rnd_timeout", timeout_o, exp_timeout());
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; stb = '0; cyc = '0; we = '0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
    for (int i = 0; i < N; i++) begin adr[i] = '0; wdat[i] = '0; sel[i] = '0; end
  endtask

  task automatic do_reset();
    clear_i = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] stb;
    logic         ack;
    logic         err;
    logic [N-1:0] e_grant;
    logic         e_stb;
    logic [N-1:0] e_ack;
    logic [N-1:0] e_err;
  } vec_t;

  vec_t vt[14];

  initial begin
    // Inputs are applied, outputs checked mid-cycle, then the clock advances.
    vt[0]  = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
    vt[1]  = '{2'b11, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 2'b01, 2'b00};
    vt[2]  = '{2'b11, 2'b01, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 2'b01};
    vt[3]  = '{2'b10, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00};
    vt[4]  = '{2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
    vt[5]  = '{2'b10, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
    vt[6]  = '{2'b10, 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00};
    vt[7]  = '{2'b11, 2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 2'b00, 2'b00};
    vt[8]  = '{2'b01, 2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 2'b00, 2'b00};
    vt[9]  = '{2'b11, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00};
    vt[10] = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
    vt[11] = '{2'b11, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 2'b00};
    vt[12] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00};
    vt[13] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};

    clear_i = 1'b1;
    idle_inputs();
    #2;
    chk("reset_grant", grant, 2'b00);
    chk("reset_stb", s_stb_o, 1'b0);
    chk("reset_timeout", timeout_o, 1'b0);
    do_reset();

    // Table: contention, rotation, hand-over gap, no preemption, routing and dropped responses.
    for (int i = 0; i < 14; i++) begin
      req = vt[i].req; stb = vt[i].stb; cyc = vt[i].stb;
      s_ack_i = vt[i].ack; s_err_i = vt[i].err;
      #4;
      chk($sformatf("vec%0d_grant", i), grant, vt[i].e_grant);
      chk($sformatf("vec%0d_stb", i), s_stb_o, vt[i].e_stb);
      chk($sformatf("vec%0d_cyc", i), s_cyc_o, vt[i].e_stb);
      chk($sformatf("vec%0d_ack", i), m_ack_o, vt[i].e_ack);
      chk($sformatf("vec%0d_err", i), m_err_o, vt[i].e_err);
      tick();
    end

    // Single request from reset and ack routing to master 1.
    do_reset();
    req = 2'b10; adr[0] = 30'h3abc; adr[1] = 30'h100;
    #4;
    chk("single_pre_grant", grant, 2'b00);
    tick();
    stb = 2'b10; cyc = 2'b10; s_ack_i = 1'b1; s_dat_i = 32'hdeadbeef;
    #4;
    chk("single_grant", grant, 2'b10);
    chk("single_adr", s_adr_o, 30'h100);
    chk("ack_route", m_ack_o, 2'b10);
    chk("ack_rdat", m_dat_o, 32'hdeadbeef);
    tick();

    // Asynchronous clear mid-transfer drops the bus before the next edge.
    do_reset();
    req = 2'b01; stb = 2'b01; cyc = 2'b01;
    tick();
    #2;
    chk("midrst_pre_stb", s_stb_o, 1'b1);
    s_ack_i = 1'b1;
    clear_i = 1'b1;
    #1;
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_stb", s_stb_o, 1'b0);
    chk("midrst_cyc", s_cyc_o, 1'b0);
    chk("midrst_ack", m_ack_o, 2'b00);
    do_reset();

    // Watchdog: strobe held without termination from the first owned cycle.
    req = 2'b01; stb = 2'b01; cyc = 2'b01;
    tick();
    for (int j = 0; j < 12; j++) begin
      #4;
`ifdef BUS_ARBITER_TIMEOUT_EN
      chk($sformatf("wd_timeout_c%0d", j), timeout_o, j == TO);
      chk($sformatf("wd_err_c%0d", j), m_err_o, (j == TO) ? 2'b01 : 2'b00);
`else
      chk($sformatf("wd_timeout_c%0d", j), timeout_o, 1'b0);
      chk($sformatf("wd_err_c%0d", j), m_err_o, 2'b00);
`endif
      chk($sformatf("wd_stb_c%0d", j), s_stb_o, 1'b1);
      tick();
    end

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        req[i]  = ($urandom_range(0, 3) != 0);
        stb[i]  = $urandom_range(0, 1);
        cyc[i]  = stb[i] | ($urandom_range(0, 3) == 0);
        we[i]   = $urandom_range(0, 1);
        adr[i]  = AW'($urandom);
        wdat[i] = $urandom;
        sel[i]  = 4'($urandom);
      end
      s_ack_i = ($urandom_range(0, 3) == 0);
      s_err_i = ($urandom_range(0, 9) == 0);
      s_dat_i = $urandom;
      #4;
      check_model();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
